// File: rtl/fifo_alu_sequencer.sv
// fifo_alu_sequencer: pops operand pairs (A then B) from the operand FIFO,
// runs the latched ALU operation on each pair and reports a registered
// result with zero/carry/overflow flags, then pulses done.
//
// FIFO read handshake: fifo_rd_en is a single-cycle pop request. The FIFO
// answers exactly one cycle later with either fifo_rd_ack (fifo_dout holds
// the popped word) or fifo_rd_err (FIFO was empty, nothing popped). When
// both are high the ack wins and the error is not counted. With neither
// high the sequencer keeps waiting. Answers arriving while not waiting
// (e.g. after a reset) are ignored.
//
// dbg_state exposes the FSM state (IDLE=0, REQ_A=1, WAIT_A=2, REQ_B=3,
// WAIT_B=4, EXEC=5, FIN=6).
module fifo_alu_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 4,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [CNT_W-1:0]  num_pairs,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_rd_ack,
  input  logic              fifo_rd_err,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_v,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  underflow_cnt,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_A  = 3'd1,
    WAIT_A = 3'd2,
    REQ_B  = 3'd3,
    WAIT_B = 3'd4,
    EXEC   = 3'd5,
    FIN    = 3'd6
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;

  state_t            state;
  logic [2:0]        op_reg;
  logic [CNT_W-1:0]  remaining;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;

  logic [DATA_W:0]   sum_ext;
  logic [DATA_W:0]   diff_ext;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_v;

  // Control outputs are pure decodes of the registered state.
  assign fifo_rd_en = (state == REQ_A) || (state == REQ_B);
  assign busy       = (state != IDLE);
  assign done       = (state == FIN);
  assign dbg_state  = state;

  // ALU on the captured operands; carry/overflow only meaningful for ADD/SUB.
  always_comb begin
    sum_ext  = {1'b0, a_reg} + {1'b0, b_reg};
    diff_ext = {1'b0, a_reg} - {1'b0, b_reg};
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (op_reg)
      OP_ADD: begin
        alu_res = sum_ext[DATA_W-1:0];
        alu_c   = sum_ext[DATA_W];
        alu_v   = (a_reg[DATA_W-1] == b_reg[DATA_W-1]) &&
                  (sum_ext[DATA_W-1] != a_reg[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = diff_ext[DATA_W-1:0];
        alu_c   = diff_ext[DATA_W];
        alu_v   = (a_reg[DATA_W-1] != b_reg[DATA_W-1]) &&
                  (diff_ext[DATA_W-1] != a_reg[DATA_W-1]);
      end
      OP_AND:  alu_res = a_reg & b_reg;
      OP_OR:   alu_res = a_reg | b_reg;
      OP_XOR:  alu_res = a_reg ^ b_reg;
      OP_SHL:  alu_res = a_reg << b_reg[4:0];
      OP_SHR:  alu_res = a_reg >> b_reg[4:0];
      default: alu_res = a_reg;
    endcase
  end

  // Sequencer FSM with its datapath registers and the underflow counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      op_reg        <= '0;
      remaining     <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      result        <= '0;
      flag_z        <= 1'b0;
      flag_c        <= 1'b0;
      flag_v        <= 1'b0;
      result_valid  <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      result_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_reg    <= op;
            remaining <= num_pairs;
            state     <= (num_pairs == '0) ? FIN : REQ_A;
          end
        end
        REQ_A: state <= WAIT_A;
        WAIT_A: begin
          if (fifo_rd_ack) begin
            a_reg <= fifo_dout;
            state <= REQ_B;
          end else if (fifo_rd_err) begin
            if (underflow_cnt != '1) underflow_cnt <= underflow_cnt + 1'b1;
            state <= REQ_A;
          end
        end
        REQ_B: state <= WAIT_B;
        WAIT_B: begin
          if (fifo_rd_ack) begin
            b_reg <= fifo_dout;
            state <= EXEC;
          end else if (fifo_rd_err) begin
            if (underflow_cnt != '1) underflow_cnt <= underflow_cnt + 1'b1;
            state <= REQ_B;
          end
        end
        EXEC: begin
          result       <= alu_res;
          flag_z       <= (alu_res == '0);
          flag_c       <= alu_c;
          flag_v       <= alu_v;
          result_valid <= 1'b1;
          remaining    <= remaining - 1'b1;
          // remaining still holds the count including the pair just finished
          state        <= (remaining > CNT_W'(1)) ? REQ_A : FIN;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_alu_sequencer.sv
// Bench for fifo_alu_sequencer: a behavioural FIFO responder, a
// spec-level ALU/timing model and a single per-cycle compare process.
module tb_fifo_alu_sequencer;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int ERR_W  = 8;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [2:0]        op = '0;
  logic [CNT_W-1:0]  num_pairs = '0;
  logic [DATA_W-1:0] fifo_dout = '0;
  logic              fifo_rd_ack = 1'b0;
  logic              fifo_rd_err = 1'b0;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              flag_z, flag_c, flag_v;
  logic              busy, done;
  logic [ERR_W-1:0]  underflow_cnt;
  logic [2:0]        dbg_state;

  fifo_alu_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .num_pairs(num_pairs),
    .fifo_dout(fifo_dout), .fifo_rd_ack(fifo_rd_ack), .fifo_rd_err(fifo_rd_err),
    .fifo_rd_en(fifo_rd_en), .result(result), .result_valid(result_valid),
    .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .busy(busy), .done(done),
    .underflow_cnt(underflow_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared bench state ----------------
  // driver-owned controls
  logic [31:0] fifo_mem[$];
  bit  silent = 0, rand_err = 0, chk_on = 0;
  int  stall_req = 0, both_req = 0, inject_req = 0;
  int  pin_n = 0, pin_gap = 0;
  bit  pin_uf_on = 0;
  int  pin_uf = 0;
  logic [31:0] pin_res[4];
  logic [2:0]  pin_f[4];   // {z,c,v}

  // responder-owned
  typedef struct { int cyc; logic [31:0] res; logic z, c, v; } exp_t;
  exp_t exp_q[$];
  int  fifo_rd_ptr = 0, stall_used = 0, both_used = 0, inject_used = 0;
  int  pop_idx = 0, pairs_done = 0, seen_seq = 0, done_seq = -1, done_cyc = -1;
  bit  rd_last = 0, err_now = 0;
  logic [31:0] a_tmp = '0;

  // compare-owned (model)
  int  tests = 0, fails = 0;
  int  cmd_seq = 0, exp_idx = 0;
  bit  m_busy = 0, prev_rd = 0;
  int  m_n = 0, m_k = 0, m_errs = 0, m_rd = 0, m_vcnt = 0, last_v_cyc = 0, m_uf = 0;
  logic [2:0]  m_op = '0;
  logic [31:0] m_res = '0;
  logic m_z = 0, m_c = 0, m_v = 0;

  // ---------------- spec-level ALU model ----------------
  function automatic void alu_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic z, output logic c, output logic v);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint s;
    c = 0; v = 0;
    case (o)
      3'd0: begin r = 32'(ua + ub); c = (ua + ub) > 64'hFFFF_FFFF; s = sa + sb;
                  v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd1: begin r = 32'(ua - ub); c = (ua < ub); s = sa - sb;
                  v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[4:0];
      3'd6: r = a >> b[4:0];
      default: r = a;
    endcase
    z = (r == 0);
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- FIFO responder (answers one cycle after rd_en) ----------------
  always @(posedge clk) begin
    exp_t e;
    logic [31:0] d;
    #1;
    fifo_rd_ack = 0; fifo_rd_err = 0; err_now = 0;
    if (seen_seq != cmd_seq) begin seen_seq = cmd_seq; pop_idx = 0; pairs_done = 0; end
    if (inject_used != inject_req) begin
      inject_used++;
      fifo_rd_ack = 1;
      fifo_dout = (fifo_rd_ptr < fifo_mem.size()) ? fifo_mem[fifo_rd_ptr] : 32'h0;
      fifo_rd_ptr++;
    end else if (rd_last && !silent) begin
      if (stall_used != stall_req || fifo_rd_ptr >= fifo_mem.size() ||
          (rand_err && $urandom_range(0, 3) == 0)) begin
        if (stall_used != stall_req) stall_used++;
        fifo_rd_err = 1; err_now = 1; fifo_dout = $urandom;
      end else begin
        d = fifo_mem[fifo_rd_ptr]; fifo_rd_ptr++;
        fifo_dout = d; fifo_rd_ack = 1;
        if (both_used != both_req) begin both_used++; fifo_rd_err = 1; end
        if (pop_idx % 2 == 0) a_tmp = d;
        else begin
          alu_model(m_op, a_tmp, d, e.res, e.z, e.c, e.v);
          e.cyc = cyc + 2;
          exp_q.push_back(e);
          pairs_done++;
          if (pairs_done == m_n) begin done_seq = cmd_seq; done_cyc = cyc + 2; end
        end
        pop_idx++;
      end
    end
    rd_last = fifo_rd_en;
  end

  // ---------------- compare process (every cycle, on negedge) ----------------
  always @(negedge clk) begin
    bit exp_v, exp_d;
    if (chk_on) begin
      exp_v = (exp_idx < exp_q.size()) && (exp_q[exp_idx].cyc == cyc);
      if (exp_v) begin
        m_res = exp_q[exp_idx].res; m_z = exp_q[exp_idx].z;
        m_c = exp_q[exp_idx].c; m_v = exp_q[exp_idx].v;
        exp_idx++;
      end
      exp_d = m_busy && ((m_n == 0 && cyc == m_k + 1) || (done_seq == cmd_seq && done_cyc == cyc));
      chk("result_valid", result_valid, exp_v);
      chk("result", result, m_res);
      chk("flag_z", flag_z, m_z);
      chk("flag_c", flag_c, m_c);
      chk("flag_v", flag_v, m_v);
      chk("done", done, exp_d);
      chk("busy", busy, m_busy);
      chk("underflow_cnt", underflow_cnt, m_uf);
      chk("rd_en_legal", fifo_rd_en & (prev_rd | ~m_busy), 0);
      if (!m_busy) chk("state_idle", dbg_state, 0);
      if (m_busy && result_valid) begin
        if (m_vcnt < pin_n) begin
          chk("pin_result", result, pin_res[m_vcnt]);
          chk("pin_flags", {flag_z, flag_c, flag_v}, pin_f[m_vcnt]);
          if (m_vcnt > 0 && pin_gap != 0) chk("pin_gap", cyc - last_v_cyc, pin_gap);
        end
        last_v_cyc = cyc;
        m_vcnt++;
      end
      if (m_busy && fifo_rd_en) m_rd++;
      if (m_busy && done) begin
        chk("done_cycle", cyc, m_k + 1 + 5 * m_n + 2 * m_errs);
        chk("pair_count", m_vcnt, m_n);
        chk("rd_count", m_rd, 2 * m_n + m_errs);
        if (pin_uf_on) chk("pin_underflow", underflow_cnt, pin_uf);
      end
      prev_rd = fifo_rd_en;
    end
    // model update for the next cycle
    if (reset) begin
      m_busy = 0; m_res = '0; m_z = 0; m_c = 0; m_v = 0; m_uf = 0;
      exp_idx = exp_q.size();
    end else begin
      if (err_now) begin
        if (m_uf < (1 << ERR_W) - 1) m_uf++;
        m_errs++;
      end
      if (exp_d) m_busy = 0;
      else if (!m_busy && start) begin
        m_busy = 1; m_op = op; m_n = num_pairs; m_k = cyc;
        m_errs = 0; m_rd = 0; m_vcnt = 0; cmd_seq++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic run_cmd(input logic [2:0] o, input int n, input bit poke);
    bit got = 0;
    op = o; num_pairs = n[CNT_W-1:0]; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
      else begin
        tick();
        if (poke) begin start = 1'($urandom_range(0, 1)); op = 3'($urandom); num_pairs = CNT_W'($urandom); end
      end
    end
    start = 0;
    if (!got) begin
      $display("FAIL done_timeout: got no done expected done within 4000 cycles");
      $fatal(1, "timeout");
    end
    tick(); tick();
    pin_n = 0; pin_gap = 0; pin_uf_on = 0;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int rdc;
    int n;
    reset = 1;
    repeat (3) tick();
    chk_on = 1;
    tick(); tick();
    reset = 0;
    tick();

    // ADD of 1+2, 3+4 with start pokes while busy
    fifo_mem.push_back(1); fifo_mem.push_back(2); fifo_mem.push_back(3); fifo_mem.push_back(4);
    pin_n = 2; pin_res[0] = 3; pin_f[0] = 3'b000; pin_res[1] = 7; pin_f[1] = 3'b000;
    pin_gap = 5; pin_uf_on = 1; pin_uf = 0;
    run_cmd(3'd0, 2, 1);

    // SUB 1-2: borrow
    fifo_mem.push_back(32'h1); fifo_mem.push_back(32'h2);
    pin_n = 1; pin_res[0] = 32'hFFFF_FFFF; pin_f[0] = 3'b010;
    run_cmd(3'd1, 1, 0);

    // ADD signed overflow
    fifo_mem.push_back(32'h7FFF_FFFF); fifo_mem.push_back(32'h1);
    pin_n = 1; pin_res[0] = 32'h8000_0000; pin_f[0] = 3'b001;
    run_cmd(3'd0, 1, 0);

    // XOR with three read-on-empty retries
    stall_req += 3;
    fifo_mem.push_back(32'hA5A5_A5A5); fifo_mem.push_back(32'hA5A5_A5A5);
    pin_n = 1; pin_res[0] = 32'h0; pin_f[0] = 3'b100; pin_uf_on = 1; pin_uf = 3;
    run_cmd(3'd4, 1, 0);

    // zero pairs: done next cycle, no pops
    pin_uf_on = 1; pin_uf = 3;
    run_cmd(3'd3, 0, 0);

    // ack and err together: ack wins, err not counted
    both_req++;
    fifo_mem.push_back(32'd5); fifo_mem.push_back(32'd9);
    pin_n = 1; pin_res[0] = 32'd14; pin_f[0] = 3'b000; pin_uf_on = 1; pin_uf = 3;
    run_cmd(3'd0, 1, 0);

    // underflow counter saturates at all-ones
    stall_req += 260;
    fifo_mem.push_back(32'h1234_5678); fifo_mem.push_back(32'h0);
    pin_n = 1; pin_res[0] = 32'h1234_5678; pin_f[0] = 3'b000; pin_uf_on = 1; pin_uf = 255;
    run_cmd(3'd7, 1, 0);

    // reset while waiting on B, then a late ack
    fifo_mem.push_back(32'hDEAD_0001); fifo_mem.push_back(32'hDEAD_0002);
    op = 3'd0; num_pairs = 1; start = 1;
    tick();
    start = 0;
    rdc = 0;
    for (int i = 0; i < 100 && rdc < 2; i++) begin
      @(negedge clk);
      if (fifo_rd_en) rdc++;
    end
    if (rdc < 2) begin
      $display("FAIL reqb_timeout: got %0d pops expected 2", rdc);
      $fatal(1, "timeout");
    end
    silent = 1;
    tick();
    reset = 1;
    tick();
    reset = 0;
    inject_req++;
    repeat (4) tick();
    silent = 0;

    // SHL after the abort
    fifo_mem.push_back(32'h1); fifo_mem.push_back(32'h4);
    pin_n = 1; pin_res[0] = 32'h10; pin_f[0] = 3'b000; pin_uf_on = 1; pin_uf = 0;
    run_cmd(3'd5, 1, 0);

    // randomized commands, with retries and busy-time pokes
    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(0, 15);
      rand_err = 1'($urandom_range(0, 1));
      for (int j = 0; j < 2 * n; j++) fifo_mem.push_back(pick_val());
      if ($urandom_range(0, 7) == 0) both_req++;
      run_cmd(3'($urandom_range(0, 7)), n, 1);
    end
    rand_err = 0;

    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_alu_sequencer.md
# fifo_alu_sequencer

Downstream consumer of the 32-bit operand FIFO in the arithmetic & logical computing system. On a start command it pops operand pairs (A then B) from the FIFO through its `rd_en`/`rd_ack`/`rd_err` handshake. It executes the selected ALU operation on each pair and presents one registered result plus flags per pair, then signals completion. It replaces hand-driven `rd_en` sequencing at the top level.

## Interface
- `DATA_W`, 32, operand/result width; must match FIFO data width.
- `CNT_W`, 4, width of `num_pairs`.
- `ERR_W`, 8, width of the underflow counter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle command; sampled only in IDLE.
- `op`  in  3  operation select; latched on accepted `start`.
- `num_pairs`  in  CNT_W  operand pairs to process; latched on accepted `start`.
- `fifo_dout`  in  DATA_W  FIFO read data; valid when `fifo_rd_ack`=1.
- `fifo_rd_ack`  in  1  FIFO read-success, one cycle after a sampled `rd_en`.
- `fifo_rd_err`  in  1  FIFO read-on-empty, one cycle after a sampled `rd_en`.
- `fifo_rd_en`  out  1  pop request to FIFO.
- `result`  out  DATA_W  last ALU result (registered).
- `result_valid`  out  1  one-cycle pulse per completed pair.
- `flag_z`, `flag_c`, `flag_v`  out  1 each  zero / carry-borrow / signed overflow of `result`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the command completes.
- `underflow_cnt`  out  ERR_W  saturating count of `fifo_rd_err` since reset.

## Operation
- States: IDLE, REQ_A, WAIT_A, REQ_B, WAIT_B, EXEC, FIN.
- IDLE: on `start`=1, latch `op` and `num_pairs` into `remaining`.
  - If `num_pairs`=0, go to FIN.
  - Otherwise go to REQ_A.
- REQ_A / REQ_B: `fifo_rd_en`=1 (decoded from state, one cycle only), then go to WAIT_A / WAIT_B.
- WAIT_x, in the cycle following REQ_x:
  - `fifo_rd_ack`=1: capture `fifo_dout` into `a_reg`/`b_reg`; go to REQ_B / EXEC.
  - `fifo_rd_err`=1: increment `underflow_cnt` (saturate at all-ones) and return to REQ_x. Retries are unlimited.
  - Both high: ack takes priority and err is not counted.
  - Neither high: stay in WAIT_x.
- EXEC:
  - Register `result` and flags.
  - Set `result_valid` for the next cycle.
  - Decrement `remaining`.
  - Go to REQ_A if `remaining`>1, else FIN.
- FIN: `done`=1 for one cycle, then IDLE.
- `start` while `busy` is ignored. `op`/`num_pairs` changes after acceptance have no effect.
- Ops (A=`a_reg`, B=`b_reg`, all results truncated to DATA_W):
  - 000 ADD: A+B. `c` = carry out.
  - 001 SUB: A−B. `c` = borrow (A<B unsigned).
  - 010 AND; 011 OR; 100 XOR.
  - 101 SHL: A<<B[4:0]. 110 SHR: A>>B[4:0], logical.
  - 111 PASS: A.
- `v` = signed overflow for ADD/SUB; 0 for all other ops. `c` is 0 for all ops other than ADD/SUB.
- `z` = (result==0) for every op.
- `result` and flags hold their values until the next EXEC.

## Timing
- Reset (sampled high at an edge):
  - Outputs after that edge: `fifo_rd_en`=0, `result`=0, all flags 0, `result_valid`=0, `busy`=0, `done`=0, `underflow_cnt`=0.
  - State returns to IDLE.
  - Reset mid-operation aborts the command; no `done` pulse is issued.
  - A `fifo_rd_ack`/`fifo_rd_err` arriving after reset is ignored.
- Accepted `start` at edge k:
  - `busy`=1 and `fifo_rd_en`=1 in cycle k+1.
  - With no underflows, each pair takes 5 cycles (REQ_A, WAIT_A, REQ_B, WAIT_B, EXEC).
  - `result_valid` is high in the cycle after EXEC.
  - For N pairs without errors, `done` is high in cycle k+1+5N. It coincides with the last `result_valid`.
- Each `fifo_rd_err` adds 2 cycles (WAIT→REQ retry).
- `num_pairs`=0: `done` in cycle k+1; no `fifo_rd_en`.
- `fifo_rd_en` is never high in two consecutive cycles.

## Test plan
- Reset, preload FIFO with 1,2,3,4; start ADD with `num_pairs`=2. Required response:
  - `result_valid` pulses with 3, then 7, 5 cycles apart.
  - `done` on the second pulse; `underflow_cnt`=0.
- Preload 0x0000_0001, 0x0000_0002; start SUB with `num_pairs`=1. Required response:
  - `result`=0xFFFF_FFFF, `flag_c`=1, `flag_v`=0, `flag_z`=0.
- Preload 0x7FFF_FFFF, 0x0000_0001; start ADD. Required response:
  - `result`=0x8000_0000, `flag_v`=1, `flag_c`=0.
- Empty FIFO; start XOR with `num_pairs`=1; after 3 `rd_err` retries write 0xA5A5_A5A5 and 0xA5A5_A5A5. Required response:
  - `result`=0, `flag_z`=1, `underflow_cnt`=3, `done` pulse.
- Start with `num_pairs`=0. Required response: `done` one cycle later, `fifo_rd_en` stays 0. Also pulse `start` while `busy`: no effect on the pair count.
- Assert `reset` while in WAIT_B, then deliver a late `rd_ack`. Required response:
  - All outputs are 0 and state is IDLE.
  - No `result_valid` or `done` is issued.
  - A following SHL of 0x1 by 4 returns 0x10.
